// File: rtl/cic_decimator.sv
// Third-order CIC decimator (M = 1) feeding the Goertzel detector in the 130 MHz domain.
// Integrators run at the input rate; the comb runs as a 4-stage strobed pipeline after each decimation event.
module cic_decimator #(
  parameter int IN_W      = 16,
  parameter int DECIM     = 100,
  parameter int ACC_W     = 36,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic [7:0]              phase
);

  localparam logic [7:0] PH_LAST = 8'(DECIM - 1);
  localparam int         EXT_W   = ACC_W + OUT_W;

  logic [ACC_W-1:0] i1, i2, i3;
  logic [ACC_W-1:0] d1, d2, d3;
  logic [ACC_W-1:0] c1, c2, c3;
  logic             v0, v1, v2, v3;

  logic [ACC_W-1:0]        x_ext;
  logic [ACC_W-1:0]        i1_nx, i2_nx, i3_nx;
  logic                    dec_evt;
  logic signed [EXT_W-1:0] c3_ext;
  logic [OUT_W-1:0]        out_nx;

  always_comb begin
    x_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    i1_nx   = i1 + x_ext;
    i2_nx   = i2 + i1_nx;
    i3_nx   = i3 + i2_nx;
    dec_evt = in_valid && (phase == PH_LAST);
    // Widen before the shift so the result sign-extends into OUT_W for any legal ACC_W/OUT_SHIFT.
    c3_ext  = {{OUT_W{c3[ACC_W-1]}}, c3};
    out_nx  = OUT_W'(c3_ext >>> OUT_SHIFT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      c1        <= '0;
      c2        <= '0;
      c3        <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      phase     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      c1        <= '0;
      c2        <= '0;
      c3        <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      phase     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_valid) begin
        i1    <= i1_nx;
        i2    <= i2_nx;
        i3    <= i3_nx;
        phase <= dec_evt ? 8'd0 : phase + 8'd1;
      end
      v0 <= dec_evt;

      // i3 here still holds the value written on the decimation edge.
      if (v0) begin
        c1 <= i3 - d1;
        d1 <= i3;
      end
      v1 <= v0;

      if (v1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      v2 <= v1;

      if (v2) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end
      v3 <= v2;

      if (v3) out_data <= out_nx;
      out_valid <= v3;
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: reset, DC gain/latency, negative DC, gaps, wrap, clear.
// Expected outputs derive from I3(n) = x*n(n+1)(n+2)/6 sampled every 100 inputs, then three first differences and >>>4.
module tb_cic_decimator;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               clear;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [31:0] out_data;
  logic [7:0]         phase;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          st_pos[$];
  longint      st_val[$];
  logic [7:0]  ph_q[$];
  longint      od_q[$];

  always #4 clock = ~clock;

  cic_decimator dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .phase     (phase)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic longint pos(input int i);
    return (i < st_pos.size()) ? longint'(st_pos[i]) : -1;
  endfunction

  function automatic longint val(input int i);
    return (i < st_val.size()) ? st_val[i] : -1;
  endfunction

  // Drive n clock steps of DC value x; gap=1 asserts in_valid only on odd steps.
  task automatic run(input int n, input logic signed [15:0] x, input bit gap);
    st_pos.delete();
    st_val.delete();
    ph_q.delete();
    od_q.delete();
    clear   = 1'b0;
    in_data = x;
    for (int k = 1; k <= n; k++) begin
      in_valid = gap ? (k % 2 == 1) : 1'b1;
      @(posedge clock);
      #1;
      ph_q.push_back(phase);
      od_q.push_back(longint'(out_data));
      if (out_valid) begin
        st_pos.push_back(k);
        st_val.push_back(longint'(out_data));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd12345;
    @(posedge clock);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_phase", phase, 0);
    chk("clear_data", out_data, 0);
    chk("clear_valid", out_valid, 0);
  endtask

  initial begin
    reset_n  = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1 reset_n = 1'b0;
    #9;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_phase", phase, 0);
    #5 reset_n = 1'b1;

    // DC 1000: startup transient, latency, hold, phase wrap
    run(410, 16'sd1000, 1'b0);
    chk("dc_count", st_pos.size(), 4);
    chk("dc_pos0", pos(0), 104);
    chk("dc_pos1", pos(1), 204);
    chk("dc_pos2", pos(2), 304);
    chk("dc_pos3", pos(3), 404);
    chk("dc_val0", val(0), 10731250);
    chk("dc_val1", val(1), 52393750);
    chk("dc_val2", val(2), 62500000);
    chk("dc_val3", val(3), 62500000);
    chk("dc_phase99", ph_q[98], 99);
    chk("dc_phase_wrap", ph_q[99], 0);
    chk("dc_pre_strobe", od_q[102], 0);
    chk("dc_hold", od_q[149], 10731250);
    chk("dc_hold2", od_q[250], 52393750);

    // asynchronous reset mid-frame with a nonzero output held
    #2 reset_n = 1'b0;
    #1;
    chk("arst_data", out_data, 0);
    chk("arst_phase", phase, 0);
    chk("arst_valid", out_valid, 0);
    #2 reset_n = 1'b1;

    run(410, -16'sd1, 1'b0);
    chk("neg1_count", st_pos.size(), 4);
    chk("neg1_pos0", pos(0), 104);
    chk("neg1_val0", val(0), -10732);
    chk("neg1_val1", val(1), -52394);
    chk("neg1_val2", val(2), -62500);
    chk("neg1_val3", val(3), -62500);

    do_clear();
    run(310, -16'sd32768, 1'b0);
    chk("negmax_count", st_pos.size(), 3);
    chk("negmax_val0", val(0), -351641600);
    chk("negmax_val2", val(2), -2048000000);

    // in_valid toggling: frames stretch to 200 clocks, same values
    do_clear();
    run(810, 16'sd1000, 1'b1);
    chk("gap_count", st_pos.size(), 4);
    chk("gap_pos0", pos(0), 203);
    chk("gap_pos1", pos(1), 403);
    chk("gap_pos3", pos(3), 803);
    chk("gap_val0", val(0), 10731250);
    chk("gap_val2", val(2), 62500000);
    chk("gap_val3", val(3), 62500000);
    chk("gap_phase99", ph_q[197], 99);
    chk("gap_phase_wrap", ph_q[198], 0);

    // full-scale positive DC: integrators wrap modulo 2^36
    do_clear();
    run(510, 16'sd32767, 1'b0);
    chk("wrap_count", st_pos.size(), 5);
    chk("wrap_val0", val(0), 351630868);
    chk("wrap_val2", val(2), 2047937500);
    chk("wrap_val3", val(3), 2047937500);
    chk("wrap_val4", val(4), 2047937500);

    // clear at T+2 of a pending event discards it and restarts the startup sequence
    do_clear();
    run(101, 16'sd1000, 1'b0);
    chk("pend_none_yet", st_pos.size(), 0);
    chk("pend_phase", ph_q[100], 1);
    do_clear();
    run(310, 16'sd1000, 1'b0);
    chk("clr_count", st_pos.size(), 3);
    chk("clr_pos0", pos(0), 104);
    chk("clr_val0", val(0), 10731250);
    chk("clr_val1", val(1), 52393750);
    chk("clr_val2", val(2), 62500000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
